// File: rtl/spi_xfer_arbiter_pkg.sv
// Shared definitions for the SPI transfer arbiter: FSM encoding, byte width
// and width helpers used to size indices and the shared cycle counter.
package spi_pkg;

   localparam int SPI_W = 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_START = 3'd2;
   localparam logic [2:0] ST_BUSY  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [2:0] ST_GAP   = 3'd5;

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // One counter serves SETUP, BUSY and GAP, so size it for the longest phase.
   function automatic int cnt_w(input int timeout, input int setup, input int gap);
      int m;
      m = timeout;
      if (setup > m) m = setup;
      if (gap > m) m = gap;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/spi_xfer_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Produces the winner index and its one-hot form.
module spi_rr_arbiter
   import spi_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx,
   output logic [N_REQ-1:0] onehot
);

   always_comb begin
      int cand;
      logic [IDX_W-1:0] cand_idx;
      any      = 1'b0;
      idx      = '0;
      cand     = 0;
      cand_idx = '0;
      for (int o = 0; o < N_REQ; o++) begin
         cand = int'(ptr) + o;
         if (cand >= N_REQ) cand = cand - N_REQ;
         cand_idx = IDX_W'(cand);
         if (!any && req[cand_idx]) begin
            any = 1'b1;
            idx = cand_idx;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
         assign onehot[gi] = any && (idx == IDX_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI master between N_REQ requesters: round-robin grant, mode/data
// setup, start pulse, completion or timeout, response pulse and CS gap.
module spi_xfer_arbiter
   import spi_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int SETUP_CYC = 2,
   parameter int GAP_CYC   = 2,
   parameter int TIMEOUT   = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [SPI_W*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]       req_ckp,
   input  logic [N_REQ-1:0]       req_cph,
   output logic [N_REQ-1:0]       gnt,
   output logic [N_REQ-1:0]       rsp_valid,
   output logic                   rsp_err,
   output logic [SPI_W-1:0]       rsp_data,
   output logic [N_REQ-1:0]       cs_sel,
   output logic                   spi_strt,
   output logic [SPI_W-1:0]       spi_data_in,
   output logic                   spi_ckp,
   output logic                   spi_cph,
   input  logic                   spi_done,
   input  logic [SPI_W-1:0]       spi_rx_data
);

   localparam int IDX_W = idx_w(N_REQ);
   localparam int CNT_W = cnt_w(TIMEOUT, SETUP_CYC, GAP_CYC);

   logic [2:0]       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [IDX_W-1:0] ptr_reg;
   logic [IDX_W-1:0] win_idx_reg;
   logic [N_REQ-1:0] win_oh_reg;
   logic [SPI_W-1:0] tx_reg, rx_reg;
   logic             ckp_reg, cph_reg, err_reg;

   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;
   logic [N_REQ-1:0] pick_oh;

   spi_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
      .req    (req),
      .ptr    (ptr_reg),
      .any    (pick_any),
      .idx    (pick_idx),
      .onehot (pick_oh)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         ptr_reg     <= '0;
         win_idx_reg <= '0;
         win_oh_reg  <= '0;
         tx_reg      <= '0;
         rx_reg      <= '0;
         ckp_reg     <= 1'b0;
         cph_reg     <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         case (state_reg)
            ST_IDLE: if (pick_any) begin
               win_idx_reg <= pick_idx;
               win_oh_reg  <= pick_oh;
               tx_reg      <= req_data[pick_idx*SPI_W +: SPI_W];
               ckp_reg     <= req_ckp[pick_idx];
               cph_reg     <= req_cph[pick_idx];
            end
            // A done pulse on the final timeout cycle still counts as success.
            ST_BUSY: if (spi_done) begin
               rx_reg  <= spi_rx_data;
               err_reg <= 1'b0;
            end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
               rx_reg  <= '0;
               err_reg <= 1'b1;
            end
            ST_DONE: ptr_reg <= (win_idx_reg == IDX_W'(N_REQ - 1)) ? '0 : win_idx_reg + IDX_W'(1);
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (pick_any) state_next = ST_SETUP;
         ST_SETUP: if (cnt_reg == CNT_W'(SETUP_CYC - 1)) state_next = ST_START;
         ST_START: state_next = ST_BUSY;
         ST_BUSY:  if (spi_done || cnt_reg == CNT_W'(TIMEOUT - 1)) state_next = ST_DONE;
         ST_DONE:  state_next = ST_GAP;
         ST_GAP:   if (cnt_reg == CNT_W'(GAP_CYC - 1)) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
      // Counter restarts on every state change and counts cycles spent in the state.
      cnt_next = '0;
      if (state_next == state_reg && state_reg != ST_IDLE) cnt_next = cnt_reg + CNT_W'(1);
   end

   always_comb begin
      logic in_xfer;
      in_xfer = (state_reg == ST_SETUP) || (state_reg == ST_START) ||
                (state_reg == ST_BUSY)  || (state_reg == ST_DONE);
      gnt         = in_xfer ? win_oh_reg : '0;
      cs_sel      = in_xfer ? win_oh_reg : '0;
      spi_strt    = (state_reg == ST_START);
      rsp_valid   = (state_reg == ST_DONE) ? win_oh_reg : '0;
      rsp_err     = (state_reg == ST_DONE) && err_reg;
      rsp_data    = (state_reg == ST_DONE) ? rx_reg : '0;
      spi_data_in = tx_reg;
      spi_ckp     = ckp_reg;
      spi_cph     = cph_reg;
   end

endmodule
